// File: rtl/dh_pkg.sv
// dh_pkg: shared FSM state encoding and default game constants for the duck controller
package dh_pkg;
  localparam int H_RES = 1024;
  localparam int GROUND_Y = 576;
  localparam int DUCK_W = 64;
  localparam int H_SPEED = 4;
  localparam int FALL_SPEED = 8;
  localparam int FLY_FRAMES = 300;
  localparam int HOLD_FRAMES = 30;
  localparam int MAX_MISSES = 3;
  typedef enum logic [2:0] {IDLE, SPAWN, FLY, HIT_HOLD, FALL, ESCAPE, GAME_OVER} state_t;
endpackage

// File: rtl/duck_axis_step.sv
// duck_axis_step: one-axis move by step with clamp-and-bounce at 0 and MAX
module duck_axis_step #(
  parameter int W = 11,
  parameter int MAX = 960
) (
  input logic [W-1:0] pos,
  input logic [7:0] step,
  input logic inc,
  output logic [W-1:0] pos_next,
  output logic inc_next
);
  localparam logic signed [11:0] LIM = 12'(MAX);
  logic signed [11:0] cand;
  always_comb begin
    cand = inc ? $signed(12'(pos)) + $signed(12'(step)) : $signed(12'(pos)) - $signed(12'(step));
    pos_next = cand < 12'sd0 ? '0 : cand > LIM ? W'(MAX) : W'(cand);
    inc_next = cand < 12'sd0 ? 1'b1 : cand > LIM ? 1'b0 : inc;
  end
endmodule

// File: rtl/duck_ctl.sv
// duck_ctl: duck hunt game FSM driving duck position, score, misses and game-over
module duck_ctl import dh_pkg::*; #(
  parameter int H_RES = dh_pkg::H_RES,
  parameter int GROUND_Y = dh_pkg::GROUND_Y,
  parameter int DUCK_W = dh_pkg::DUCK_W,
  parameter int H_SPEED = dh_pkg::H_SPEED,
  parameter int FALL_SPEED = dh_pkg::FALL_SPEED,
  parameter int FLY_FRAMES = dh_pkg::FLY_FRAMES,
  parameter int HOLD_FRAMES = dh_pkg::HOLD_FRAMES,
  parameter int MAX_MISSES = dh_pkg::MAX_MISSES
) (
  input logic clk,
  input logic rst,
  input logic new_frame,
  input logic start,
  input logic trigger,
  input logic hit,
  input logic direction,
  input logic [9:0] duck_start_pos,
  input logic [2:0] duck_vertical_speed,
  output logic [10:0] duck_x,
  output logic [9:0] duck_y,
  output logic duck_visible,
  output logic duck_shot,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic game_over
);
  localparam int X_MAX = H_RES - DUCK_W;
  localparam int CW = $clog2((FLY_FRAMES > HOLD_FRAMES ? FLY_FRAMES : HOLD_FRAMES) + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic dir, y_inc, dir_n, y_inc_n, y_step_inc;
  logic [2:0] vspeed;
  logic [10:0] x_n;
  logic [9:0] y_n;
  logic [7:0] y_step;
  assign y_step = state == FLY ? 8'(vspeed) : 8'(FALL_SPEED);
  assign y_step_inc = state == FLY ? y_inc : state == FALL;
  duck_axis_step #(.W(11), .MAX(X_MAX)) u_x (
    .pos(duck_x), .step(8'(H_SPEED)), .inc(dir), .pos_next(x_n), .inc_next(dir_n)
  );
  duck_axis_step #(.W(10), .MAX(GROUND_Y)) u_y (
    .pos(duck_y), .step(y_step), .inc(y_step_inc), .pos_next(y_n), .inc_next(y_inc_n)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duck_x <= '0;
      duck_y <= 10'(GROUND_Y);
      score <= '0;
      misses <= '0;
      cnt <= '0;
      dir <= 1'b0;
      y_inc <= 1'b0;
      vspeed <= '0;
      duck_visible <= 1'b0;
      duck_shot <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        IDLE, GAME_OVER: if (start) begin
          state <= SPAWN;
          score <= '0;
          misses <= '0;
          game_over <= 1'b0;
        end
        SPAWN: begin
          state <= FLY;
          duck_x <= {1'b0, duck_start_pos} > 11'(X_MAX) ? 11'(X_MAX) : {1'b0, duck_start_pos};
          duck_y <= 10'(GROUND_Y);
          dir <= direction;
          y_inc <= 1'b0;
          vspeed <= duck_vertical_speed == 3'd0 ? 3'd1 : duck_vertical_speed;
          cnt <= '0;
          duck_visible <= 1'b1;
        end
        FLY: if (trigger && hit) begin
          state <= HIT_HOLD;
          cnt <= '0;
          score <= score + {7'd0, score != 8'hFF};
          duck_shot <= 1'b1;
        end else if (new_frame) begin
          duck_x <= x_n;
          dir <= dir_n;
          duck_y <= y_n;
          y_inc <= y_inc_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(FLY_FRAMES - 1)) state <= ESCAPE;
        end
        HIT_HOLD: if (new_frame) begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(HOLD_FRAMES - 1)) state <= FALL;
        end
        FALL: if (new_frame) begin
          duck_y <= y_n;
          if (y_n == 10'(GROUND_Y)) begin
            state <= SPAWN;
            duck_visible <= 1'b0;
            duck_shot <= 1'b0;
          end
        end
        ESCAPE: if (new_frame) begin
          duck_y <= y_n;
          if (y_n == 10'd0) begin
            misses <= misses + 4'd1;
            duck_visible <= 1'b0;
            state <= misses + 4'd1 == 4'(MAX_MISSES) ? GAME_OVER : SPAWN;
            game_over <= misses + 4'd1 == 4'(MAX_MISSES);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_duck_ctl.sv
// tb_duck_ctl: table-driven and scenario checks for duck_ctl with a scoreboard queue
module tb_duck_ctl;
  logic clk = 1'b0, rst = 1'b1, new_frame = 1'b0, start = 1'b0, trigger = 1'b0, hit = 1'b0, direction = 1'b0;
  logic [9:0] duck_start_pos = '0;
  logic [2:0] duck_vertical_speed = '0;
  logic [10:0] duck_x;
  logic [9:0] duck_y;
  logic duck_visible, duck_shot, game_over;
  logic [7:0] score;
  logic [3:0] misses;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic st, nf, tr, hi;
    logic [35:0] exp;
  } vec_t;
  typedef struct {
    string name;
    logic [35:0] exp;
  } sb_t;
  sb_t sb[$];
  vec_t tbl[10];
  always #5 clk = ~clk;
  duck_ctl dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start), .trigger(trigger), .hit(hit),
    .direction(direction), .duck_start_pos(duck_start_pos), .duck_vertical_speed(duck_vertical_speed),
    .duck_x(duck_x), .duck_y(duck_y), .duck_visible(duck_visible), .duck_shot(duck_shot),
    .score(score), .misses(misses), .game_over(game_over)
  );
  function automatic logic [35:0] pk(input int x, y, vis, shot, sc, mi, ov);
    return {11'(x), 10'(y), 1'(vis), 1'(shot), 8'(sc), 4'(mi), 1'(ov)};
  endfunction
  function automatic vec_t mk(input logic st, nf, tr, hi, input logic [35:0] e);
    vec_t v;
    v.st = st;
    v.nf = nf;
    v.tr = tr;
    v.hi = hi;
    v.exp = e;
    return v;
  endfunction
  task automatic drive(input logic st, nf, tr, hi);
    start = st;
    new_frame = nf;
    trigger = tr;
    hit = hi;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic frames(input int n);
    repeat (n) drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic rnd(input logic d, input int pos, input int vs);
    direction = d;
    duck_start_pos = 10'(pos);
    duck_vertical_speed = 3'(vs);
  endtask
  task automatic expect_rec(input string name, input logic [35:0] e);
    sb_t s;
    s.name = name;
    s.exp = e;
    sb.push_back(s);
  endtask
  task automatic check_rec();
    sb_t s;
    logic [35:0] a;
    s = sb.pop_front();
    a = {duck_x, duck_y, duck_visible, duck_shot, score, misses, game_over};
    n_cmp++;
    if (a !== s.exp) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d vis=%0b shot=%0b score=%0d misses=%0d over=%0b, required %h (got %h)",
               s.name, duck_x, duck_y, duck_visible, duck_shot, score, misses, game_over, s.exp, a);
    end
  endtask
  task automatic step_rec(input string name, input logic st, nf, tr, hi, input logic [35:0] e);
    expect_rec(name, e);
    drive(st, nf, tr, hi);
    check_rec();
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask
  task automatic until_hidden(input string name);
    int k;
    k = 0;
    while (duck_visible && k < 200) begin
      frames(1);
      k++;
    end
    chk({name, "_bound"}, int'(duck_visible), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, pk(0, 576, 0, 0, 0, 0, 0));
    tbl[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, pk(100, 576, 1, 0, 0, 0, 0));
    tbl[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, pk(104, 574, 1, 0, 0, 0, 0));
    tbl[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, pk(104, 574, 1, 0, 0, 0, 0));
    tbl[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, pk(108, 572, 1, 0, 0, 0, 0));
    tbl[5] = mk(1'b0, 1'b1, 1'b0, 1'b0, pk(112, 570, 1, 0, 0, 0, 0));
    tbl[6] = mk(1'b0, 1'b0, 1'b1, 1'b0, pk(112, 570, 1, 0, 0, 0, 0));
    tbl[7] = mk(1'b0, 1'b0, 1'b0, 1'b1, pk(112, 570, 1, 0, 0, 0, 0));
    tbl[8] = mk(1'b0, 1'b0, 1'b1, 1'b1, pk(112, 570, 1, 1, 1, 0, 0));
    tbl[9] = mk(1'b0, 1'b1, 1'b0, 1'b0, pk(112, 570, 1, 1, 1, 0, 0));
    rnd(1'b1, 100, 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step_rec("reset_over_start", 1'b1, 1'b0, 1'b0, 1'b0, pk(0, 576, 0, 0, 0, 0, 0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      step_rec($sformatf("vec%0d", i), tbl[i].st, tbl[i].nf, tbl[i].tr, tbl[i].hi, tbl[i].exp);
    frames(28);
    expect_rec("hold29", pk(112, 570, 1, 1, 1, 0, 0));
    check_rec();
    rnd(1'b1, 1000, 0);
    frames(1);
    expect_rec("hold30", pk(112, 570, 1, 1, 1, 0, 0));
    check_rec();
    frames(1);
    expect_rec("fall_land", pk(112, 576, 0, 0, 1, 0, 0));
    check_rec();
    step_rec("wall_spawn", 1'b0, 1'b0, 1'b0, 1'b0, pk(960, 576, 1, 0, 1, 0, 0));
    step_rec("wall_clamp", 1'b0, 1'b1, 1'b0, 1'b0, pk(960, 575, 1, 0, 1, 0, 0));
    step_rec("wall_left", 1'b0, 1'b1, 1'b0, 1'b0, pk(956, 574, 1, 0, 1, 0, 0));
    frames(297);
    expect_rec("fly299", pk(228, 277, 1, 0, 1, 0, 0));
    check_rec();
    step_rec("fly300", 1'b0, 1'b1, 1'b0, 1'b0, pk(232, 276, 1, 0, 1, 0, 0));
    step_rec("escape1", 1'b0, 1'b1, 1'b0, 1'b0, pk(232, 268, 1, 0, 1, 0, 0));
    frames(33);
    expect_rec("escape34", pk(232, 4, 1, 0, 1, 0, 0));
    check_rec();
    step_rec("miss1", 1'b0, 1'b1, 1'b0, 1'b0, pk(232, 0, 0, 0, 1, 1, 0));
    rnd(1'b1, 100, 1);
    step_rec("spawn2", 1'b0, 1'b0, 1'b0, 1'b0, pk(100, 576, 1, 0, 1, 1, 0));
    frames(299);
    expect_rec("fly299b", pk(628, 277, 1, 0, 1, 1, 0));
    check_rec();
    step_rec("hit_on_timeout", 1'b0, 1'b1, 1'b1, 1'b1, pk(628, 277, 1, 1, 2, 1, 0));
    frames(30);
    until_hidden("fall2");
    chk("fall2_y", int'(duck_y), 576);
    chk("fall2_shot", int'(duck_shot), 0);
    chk("fall2_misses", int'(misses), 1);
    chk("fall2_score", int'(score), 2);
    rnd(1'b0, 0, 7);
    frames(300);
    until_hidden("escape2");
    chk("miss2", int'(misses), 2);
    chk("miss2_over", int'(game_over), 0);
    chk("miss2_y", int'(duck_y), 0);
    frames(300);
    until_hidden("escape3");
    chk("miss3", int'(misses), 3);
    chk("miss3_over", int'(game_over), 1);
    frames(5);
    chk("over_hold", int'(game_over), 1);
    chk("over_hold_misses", int'(misses), 3);
    chk("over_hold_vis", int'(duck_visible), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_score", int'(score), 0);
    chk("restart_misses", int'(misses), 0);
    chk("restart_over", int'(game_over), 0);
    rnd(1'b1, 100, 7);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("fly3_vis", int'(duck_visible), 1);
    frames(40);
    chk("fly3_y", int'(duck_y), 296);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("fly3_score", int'(score), 1);
    frames(30);
    frames(1);
    chk("mid_fall_y", int'(duck_y), 304);
    chk("mid_fall_shot", int'(duck_shot), 1);
    rst = 1'b1;
    step_rec("reset_mid_fall", 1'b0, 1'b1, 1'b0, 1'b0, pk(0, 576, 0, 0, 0, 0, 0));
    rst = 1'b0;
    step_rec("idle_after_reset", 1'b0, 1'b1, 1'b1, 1'b1, pk(0, 576, 0, 0, 0, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
